// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32 load/store front end for a word-addressed data memory with 1-cycle read latency.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
module lsu_mem_port #(
    parameter int ADDR_W    = 8,
    parameter int MEM_WORDS = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] WORDS_L = (ADDR_W + 1)'(MEM_WORDS);

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            2'b01:   m = a[0];
            2'b10:   m = |a;
            default: m = 1'b0;
        endcase
        return m;
    endfunction
`endif

    // Half accesses always use lane pair a[1]; a[0] is either trapped or ignored.
    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = 4'b0011 << {a[1], 1'b0};
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = w;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        alo_q, alo_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              mem_request_q, mem_request_d;
    logic              mem_we_re_q, mem_we_re_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_data_in_q, mem_data_in_d;
    logic [3:0]        mem_mask_q, mem_mask_d;

    logic [ADDR_W-1:0] idx_s;
    logic              range_err_s;
    logic              misalign_s;
    logic              chk_err_s;

    // Request checks: funct3 legality, address range, optional alignment.
    always_comb begin
        idx_s       = req_addr[ADDR_W+1:2];
        range_err_s = ((req_addr >> (ADDR_W + 2)) != 32'd0) || ({1'b0, idx_s} >= WORDS_L);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s  = is_misaligned(req_funct3[1:0], req_addr[1:0]);
`else
        misalign_s  = 1'b0;
`endif
        chk_err_s   = ~funct3_legal(req_we, req_funct3) || range_err_s || misalign_s;
    end

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        funct3_d      = funct3_q;
        alo_d         = alo_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        mem_request_d = 1'b0;
        mem_we_re_d   = mem_we_re_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_mask_d    = mem_mask_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    alo_d       = req_addr[1:0];
                    rsp_rdata_d = 32'd0;
                    if (chk_err_s) begin
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        // Strobe is registered here so it is visible during ACCESS.
                        rsp_err_d     = 1'b0;
                        mem_request_d = 1'b1;
                        mem_we_re_d   = req_we;
                        mem_address_d = idx_s;
                        state_d       = ACCESS;
                        if (req_we) begin
                            mem_mask_d    = store_mask(req_funct3[1:0], req_addr[1:0]);
                            mem_data_in_d = store_data(req_funct3[1:0], req_wdata);
                        end else begin
                            mem_mask_d    = 4'b0000;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_rdata_d = load_extract(funct3_q, alo_q, mem_data_out);
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            alo_q         <= 2'b00;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= 32'd0;
            mem_mask_q    <= 4'b0000;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            funct3_q      <= funct3_d;
            alo_q         <= alo_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_mask_q    <= mem_mask_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_request = mem_request_q;
    assign mem_we_re   = mem_we_re_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_mask    = mem_mask_q;

endmodule
